// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared sequence entry layout, state encoding and ramp helper
package seq_pkg;

  localparam int SEQ_W       = 128;
  localparam int DAC0_LSB    = 0;
  localparam int DAC_W       = 14;
  localparam int RESYNC0_BIT = 14;
  localparam int DAC1_LSB    = 16;
  localparam int RESYNC1_BIT = 30;
  localparam int PDM0_LSB    = 32;
  localparam int PDM1_LSB    = 48;
  localparam int PDM2_LSB    = 64;
  localparam int PDM3_LSB    = 80;
  localparam int PDM_W       = 11;
  localparam int EN_DAC_LSB  = 96;
  localparam int EN_PDM_LSB  = 98;
  localparam int RAMP_DN_LSB = 112;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_RAMP
  } seq_state_e;

  function automatic logic [SEQ_W-1:0] ramp_force(input logic [SEQ_W-1:0] entry);
    logic [SEQ_W-1:0] r;
    r = entry;
    r[RAMP_DN_LSB +: 2] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/sequence_step_scheduler_if.sv
// rtl/sequence_step_scheduler_if.sv - sequence BRAM read port bundle
interface sequence_step_scheduler_if
  import seq_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic [SEQ_W-1:0]  bram_rdata;

  modport master (output bram_addr, output bram_en, input bram_rdata);
  modport slave  (input bram_addr, input bram_en, output bram_rdata);
endinterface

// File: rtl/seq_step_timer.sv
// rtl/seq_step_timer.sv - step period down-counter, pulses on each step boundary
module seq_step_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        run_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = run_i && (cnt_q == 32'd0);
    if (load_i) begin
      cnt_d = period_i - 32'd1;
    end else if (run_i) begin
      cnt_d = tick_o ? period_i - 32'd1 : cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sequence_step_scheduler.sv
// rtl/sequence_step_scheduler.sv - plays the sequence table to sequence_slice with prefetch
// Optional ramp-down hold on termination: SEQ_SCHED_RAMP_DOWN_EN
module sequence_step_scheduler
  import seq_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int RD_LAT      = 2,
  parameter int RAMP_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [31:0]            samples_per_step,
  input  logic [ADDR_W:0]        num_steps,
  input  logic [15:0]            num_repetitions,
  sequence_step_scheduler_if.master bram,
  output logic [SEQ_W-1:0]       seq_data,
  output logic                   busy,
  output logic [ADDR_W-1:0]      step_index,
  output logic [15:0]            rep_count,
  output logic                   step_tick,
  output logic                   done
);
  localparam logic [31:0] MIN_PERIOD = 32'(RD_LAT + 2);

  seq_state_e        state_q, state_d;
  logic [31:0]       period_q, period_d;
  logic [ADDR_W:0]   steps_q, steps_d;
  logic [15:0]       reps_q, reps_d;
  logic [ADDR_W-1:0] fetch_idx_q, fetch_idx_d;
  logic [ADDR_W-1:0] step_index_q, step_index_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              bram_en_q, bram_en_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [SEQ_W-1:0]  shadow_q, shadow_d;
  logic [SEQ_W-1:0]  seq_data_q, seq_data_d;
  logic [15:0]       rep_count_q, rep_count_d;
  logic              stop_pend_q, stop_pend_d;
  logic              step_tick_q, step_tick_d;
  logic              done_q, done_d;
  logic              timer_load, timer_tick, rd_valid, terminate;
  logic [ADDR_W-1:0] fetch_next;

`ifdef SEQ_SCHED_RAMP_DOWN_EN
  logic [31:0] ramp_cnt_q, ramp_cnt_d;
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = ^32'(RAMP_CYCLES);
`endif

  seq_step_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (timer_load),
    .run_i    (state_q == ST_RUN),
    .period_i (period_q),
    .tick_o   (timer_tick)
  );

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    steps_d      = steps_q;
    reps_d       = reps_q;
    fetch_idx_d  = fetch_idx_q;
    step_index_d = step_index_q;
    bram_addr_d  = bram_addr_q;
    bram_en_d    = 1'b0;
    shadow_d     = shadow_q;
    seq_data_d   = seq_data_q;
    rep_count_d  = rep_count_q;
    stop_pend_d  = stop_pend_q;
    step_tick_d  = 1'b0;
    done_d       = 1'b0;
    timer_load   = 1'b0;
`ifdef SEQ_SCHED_RAMP_DOWN_EN
    ramp_cnt_d   = ramp_cnt_q;
`endif
    // rd_pipe tracks the outstanding read so data is captured exactly RD_LAT cycles after bram_en
    rd_pipe_d  = (rd_pipe_q << 1) | RD_LAT'(bram_en_q);
    rd_valid   = rd_pipe_q[RD_LAT-1];
    fetch_next = (({1'b0, fetch_idx_q} + 1'b1) >= steps_q) ? '0 : fetch_idx_q + 1'b1;
    // applying index 0 again is the end of a repetition
    terminate  = stop_pend_q || stop ||
                 ((fetch_idx_q == '0) && (reps_q != 16'd0) && (rep_count_q + 16'd1 == reps_q));

    if ((state_q == ST_FILL || state_q == ST_RUN) && stop) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !stop && (num_steps != '0)) begin
          state_d      = ST_FILL;
          period_d     = (samples_per_step < MIN_PERIOD) ? MIN_PERIOD : samples_per_step;
          steps_d      = num_steps;
          reps_d       = num_repetitions;
          rep_count_d  = 16'd0;
          step_index_d = '0;
          fetch_idx_d  = '0;
          bram_addr_d  = '0;
          stop_pend_d  = 1'b0;
        end
      end
      ST_FILL: begin
        if (!bram_en_q && (rd_pipe_q == '0)) begin
          bram_en_d = 1'b1;
        end
        if (rd_valid) begin
          state_d      = ST_RUN;
          seq_data_d   = bram.bram_rdata;
          step_tick_d  = 1'b1;
          step_index_d = fetch_idx_q;
          timer_load   = 1'b1;
          fetch_idx_d  = fetch_next;
          bram_addr_d  = fetch_next;
          bram_en_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (rd_valid) begin
          shadow_d = bram.bram_rdata;
        end
        if (timer_tick) begin
          if (terminate) begin
            stop_pend_d = 1'b0;
`ifdef SEQ_SCHED_RAMP_DOWN_EN
            state_d     = ST_RAMP;
            seq_data_d  = ramp_force(seq_data_q);
            ramp_cnt_d  = 32'(RAMP_CYCLES - 1);
`else
            state_d     = ST_IDLE;
            seq_data_d  = '0;
            done_d      = 1'b1;
`endif
          end else begin
            seq_data_d   = shadow_q;
            step_tick_d  = 1'b1;
            step_index_d = fetch_idx_q;
            if (fetch_idx_q == '0) begin
              rep_count_d = rep_count_q + 16'd1;
            end
            fetch_idx_d  = fetch_next;
            bram_addr_d  = fetch_next;
            bram_en_d    = 1'b1;
          end
        end
      end
`ifdef SEQ_SCHED_RAMP_DOWN_EN
      ST_RAMP: begin
        if (ramp_cnt_q == 32'd0) begin
          state_d    = ST_IDLE;
          seq_data_d = '0;
          done_d     = 1'b1;
        end else begin
          ramp_cnt_d = ramp_cnt_q - 32'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      period_q     <= 32'd0;
      steps_q      <= '0;
      reps_q       <= 16'd0;
      fetch_idx_q  <= '0;
      step_index_q <= '0;
      bram_addr_q  <= '0;
      bram_en_q    <= 1'b0;
      rd_pipe_q    <= '0;
      shadow_q     <= '0;
      seq_data_q   <= '0;
      rep_count_q  <= 16'd0;
      stop_pend_q  <= 1'b0;
      step_tick_q  <= 1'b0;
      done_q       <= 1'b0;
`ifdef SEQ_SCHED_RAMP_DOWN_EN
      ramp_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      steps_q      <= steps_d;
      reps_q       <= reps_d;
      fetch_idx_q  <= fetch_idx_d;
      step_index_q <= step_index_d;
      bram_addr_q  <= bram_addr_d;
      bram_en_q    <= bram_en_d;
      rd_pipe_q    <= rd_pipe_d;
      shadow_q     <= shadow_d;
      seq_data_q   <= seq_data_d;
      rep_count_q  <= rep_count_d;
      stop_pend_q  <= stop_pend_d;
      step_tick_q  <= step_tick_d;
      done_q       <= done_d;
`ifdef SEQ_SCHED_RAMP_DOWN_EN
      ramp_cnt_q   <= ramp_cnt_d;
`endif
    end
  end

  assign bram.bram_addr = bram_addr_q;
  assign bram.bram_en   = bram_en_q;
  assign seq_data       = seq_data_q;
  assign busy           = (state_q != ST_IDLE);
  assign step_index     = step_index_q;
  assign rep_count      = rep_count_q;
  assign step_tick      = step_tick_q;
  assign done           = done_q;
endmodule

// File: tb/tb_sequence_step_scheduler.sv
// tb/tb_sequence_step_scheduler.sv - randomized bench against a timeline model of the scheduler
module tb_sequence_step_scheduler;
  import seq_pkg::*;

  localparam int ADDR_W      = 6;
  localparam int RD_LAT      = 2;
  localparam int RAMP_CYCLES = 16;
  localparam int BASE        = RD_LAT + 2;
`ifdef SEQ_SCHED_RAMP_DOWN_EN
  localparam int RAMP_LEN = RAMP_CYCLES;
`else
  localparam int RAMP_LEN = 0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start, stop;
  logic [31:0]           samples_per_step;
  logic [ADDR_W:0]       num_steps;
  logic [15:0]           num_repetitions;
  logic [SEQ_W-1:0]      seq_data;
  logic                  busy, step_tick, done;
  logic [ADDR_W-1:0]     step_index;
  logic [15:0]           rep_count;

  logic [SEQ_W-1:0]      mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]     rd_addr_pipe [RD_LAT];
  logic                  rd_vld_pipe [RD_LAT];

  int n_tests = 0;
  int n_fail  = 0;

  sequence_step_scheduler_if #(.ADDR_W(ADDR_W)) bram_if ();

  sequence_step_scheduler #(
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .RAMP_CYCLES(RAMP_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .samples_per_step (samples_per_step),
    .num_steps        (num_steps),
    .num_repetitions  (num_repetitions),
    .bram             (bram_if),
    .seq_data         (seq_data),
    .busy             (busy),
    .step_index       (step_index),
    .rep_count        (rep_count),
    .step_tick        (step_tick),
    .done             (done)
  );

  always #5 clk = ~clk;

  // BRAM with RD_LAT read latency; unread cycles return a garbage pattern
  always @(posedge clk) begin
    rd_addr_pipe[0] <= bram_if.bram_addr;
    rd_vld_pipe[0]  <= bram_if.bram_en;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_addr_pipe[i] <= rd_addr_pipe[i-1];
      rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
    end
  end
  assign bram_if.bram_rdata = rd_vld_pipe[RD_LAT-1] ? mem[rd_addr_pipe[RD_LAT-1]] : {4{32'hBAD0_BAD0}};

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] obs();
    return {busy, done, step_tick, bram_if.bram_en, bram_if.bram_addr, step_index, rep_count, seq_data};
  endfunction

  task automatic fill_mem(input bit counting);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = counting ? SEQ_W'(i + 1) : {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Timeline from start edge T: step k applied at T+BASE+k*p, ending at the first terminating boundary
  task automatic run_case(input string name, input int spp, input int steps, input int reps,
                          input int stop_at, input int start_at);
    int p, k_end, k_stop, end_off, k, kl, rel;
    logic busy_e, done_e, tick_e, en_e;
    logic [ADDR_W-1:0] addr_e, idx_e;
    logic [15:0] rep_e;
    logic [SEQ_W-1:0] seq_e, ramp_mask;
    ramp_mask = '0;
    ramp_mask[RAMP_DN_LSB +: 2] = 2'b11;
    p = (spp < BASE) ? BASE : spp;
    k_end = (reps != 0) ? steps * reps : 32'h4000_0000;
    if (stop_at > 0) begin
      k_stop = (stop_at - BASE + p - 1) / p;
      if (k_stop < 1) k_stop = 1;
      if (k_stop < k_end) k_end = k_stop;
    end
    end_off = BASE + k_end * p + RAMP_LEN;

    samples_per_step = 32'(spp);
    num_steps        = (ADDR_W+1)'(steps);
    num_repetitions  = 16'(reps);
    start            = 1'b1;
    @(negedge clk);
    for (int o = 0; o <= end_off + 2; o++) begin
      rel    = o - BASE;
      busy_e = (o < end_off);
      done_e = (o == end_off);
      if (o < BASE) begin
        k = 0; seq_e = '0; tick_e = 1'b0;
        idx_e = '0; rep_e = 16'd0; addr_e = '0;
      end else if (rel < k_end * p) begin
        k      = rel / p;
        seq_e  = mem[k % steps];
        tick_e = (rel % p == 0);
        idx_e  = ADDR_W'(k % steps);
        rep_e  = 16'(k / steps);
        addr_e = ADDR_W'((k + 1) % steps);
      end else begin
        kl     = k_end - 1;
        seq_e  = (o < end_off) ? (mem[kl % steps] | ramp_mask) : '0;
        tick_e = 1'b0;
        idx_e  = ADDR_W'(kl % steps);
        rep_e  = 16'(kl / steps);
        addr_e = ADDR_W'(k_end % steps);
      end
      en_e = (o == 1) || tick_e;
      check($sformatf("%s@%0d", name, o), obs(),
            {busy_e, done_e, tick_e, en_e, addr_e, idx_e, rep_e, seq_e});
      start = ((o + 1) == start_at);
      stop  = ((o + 1) == stop_at);
      samples_per_step = $urandom_range(1, 20);
      num_steps        = (ADDR_W+1)'($urandom_range(0, 8));
      num_repetitions  = 16'($urandom_range(0, 3));
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check($sformatf("%s_idle%0d", name, i), {156'd0, busy, step_tick, bram_if.bram_en, done}, 160'd0);
    end
  endtask

  initial begin
    int spp, steps, reps, stop_at, start_at;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    samples_per_step = 32'd8; num_steps = '0; num_repetitions = 16'd0;
    fill_mem(1'b1);
    repeat (4) @(negedge clk);
    check("reset_state", obs(), 160'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset", obs(), 160'd0);

    run_case("basic", 8, 4, 2, 0, 0);
    fill_mem(1'b0);
    run_case("clamp", 1, 3, 1, 0, 0);
    run_case("stop_inf", 6, 2, 0, BASE + 5 * 6 + 3, 0);
    run_case("one_step", 5, 1, 3, 0, 0);

    samples_per_step = 32'd8; num_steps = 7'd3; num_repetitions = 16'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_same", {159'd0, busy}, 160'd0);
    check_idle("start_stop", 3);

    num_steps = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_steps", {159'd0, busy}, 160'd0);
    check_idle("zero_steps", 3);

    run_case("start_busy", 6, 3, 1, 0, 9);

    samples_per_step = 32'd6; num_steps = 7'd4; num_repetitions = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_run_busy", {159'd0, busy}, {159'd0, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    check("mid_run_reset", obs(), 160'd0);
    reset = 1'b0;
    run_case("after_reset", 6, 4, 1, 0, 0);

    for (int n = 0; n < 6; n++) begin
      fill_mem(1'b0);
      spp   = $urandom_range(1, 10);
      steps = $urandom_range(1, 5);
      reps  = $urandom_range(0, 3);
      stop_at  = (reps == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(2, BASE + steps * 2 * 10) : 0;
      start_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, BASE + 4) : 0;
      run_case($sformatf("rnd%0d", n), spp, steps, reps, stop_at, start_at);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
